// File: rtl/arb_client.sv
// arb_client: per-channel burst client sitting in front of a fixed-priority
// arbiter. Each channel accepts a burst command (length minus one), raises
// its request and counts one beat per cycle in which it alone holds the
// grant. Completion is signalled by a one-cycle done pulse; any grant-protocol
// violation latches a sticky error flag.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_ni        asynchronous active-low reset
//   cmd_valid_i   per-channel command offer
//   cmd_len_i     per-channel burst length minus one, channel k at [k*LEN_W +: LEN_W]
//   cmd_ready_o   per-channel command acceptance (channel idle)
//   req_o         request vector to the arbiter (bit 0 highest priority)
//   gnt_i         grant vector from the arbiter, one-hot or zero
//   beat_valid_o  a beat was consumed in the previous cycle
//   beat_ch_o     channel of that beat (holds when no beat)
//   done_o        one-cycle pulse per channel at burst completion
//   err_o         sticky grant-protocol violation flag
//   starve_o      per-channel starvation flag
//
// Configuration: define ARB_CLIENT_STARVE_CNT_EN to build the per-channel
// starvation counters; otherwise starve_o is tied to zero.

module arb_client #(
    parameter int NUM          = 4,
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic [NUM-1:0]         cmd_valid_i,
    input  logic [NUM*LEN_W-1:0]   cmd_len_i,
    output logic [NUM-1:0]         cmd_ready_o,
    output logic [NUM-1:0]         req_o,
    input  logic [NUM-1:0]         gnt_i,
    output logic                   beat_valid_o,
    output logic [$clog2(NUM)-1:0] beat_ch_o,
    output logic [NUM-1:0]         done_o,
    output logic                   err_o,
    output logic [NUM-1:0]         starve_o
);

    localparam int CH_W = $clog2(NUM);

    if (NUM < 2 || NUM > 16 || LEN_W < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("arb_client: parameter out of range");
    end

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } ch_state_e;

    ch_state_e        state_q [NUM];
    ch_state_e        state_d [NUM];
    logic [LEN_W-1:0] rem_q   [NUM];
    logic [LEN_W-1:0] rem_d   [NUM];

    logic             beat_valid_q, beat_valid_d;
    logic [CH_W-1:0]  beat_ch_q, beat_ch_d;
    logic [NUM-1:0]   done_q, done_d;
    logic             err_q, err_d;

    logic             gnt_onehot;
    logic             gnt_multi;
    logic             beat_any;
    logic [CH_W-1:0]  beat_idx;

    // Request and ready come from registered state only, so there is no
    // combinational path from gnt_i back to req_o.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            req_o[k]       = (state_q[k] == S_WAIT);
            cmd_ready_o[k] = (state_q[k] == S_IDLE);
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block free of latches.
        gnt_onehot = ($countones(gnt_i) == 1);
        gnt_multi  = ($countones(gnt_i) > 1);
        beat_any   = 1'b0;
        beat_idx   = '0;
        done_d     = '0;
        // A grant to a channel that is not requesting is a violation too.
        err_d      = err_q | gnt_multi | (|(gnt_i & ~req_o));

        for (int k = 0; k < NUM; k++) begin
            state_d[k] = state_q[k];
            rem_d[k]   = rem_q[k];
            if (state_q[k] == S_IDLE) begin
                if (cmd_valid_i[k]) begin
                    state_d[k] = S_WAIT;
                    rem_d[k]   = cmd_len_i[k*LEN_W +: LEN_W];
                end
            end else if (gnt_i[k] && gnt_onehot) begin
                // Without a grant the counter simply holds (preemption pause).
                beat_any = 1'b1;
                beat_idx = CH_W'(k);
                // Testing zero before decrementing lets an all-ones length
                // run its full 2^LEN_W beats without wrapping.
                if (rem_q[k] == '0) begin
                    state_d[k] = S_IDLE;
                    done_d[k]  = 1'b1;
                end else begin
                    rem_d[k] = rem_q[k] - LEN_W'(1);
                end
            end
        end

        beat_valid_d = beat_any;
        beat_ch_d    = beat_any ? beat_idx : beat_ch_q;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the remaining counters are a handful of flops, not a RAM,
            // so they are reset with everything else and start at a known 0.
            for (int k = 0; k < NUM; k++) begin
                state_q[k] <= S_IDLE;
                rem_q[k]   <= '0;
            end
            beat_valid_q <= 1'b0;
            beat_ch_q    <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop, independent of order.
            state_q      <= state_d;
            rem_q        <= rem_d;
            beat_valid_q <= beat_valid_d;
            beat_ch_q    <= beat_ch_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign beat_valid_o = beat_valid_q;
    assign beat_ch_o    = beat_ch_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

`ifdef ARB_CLIENT_STARVE_CNT_EN
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt_q [NUM];
    logic [CNT_W-1:0] wait_cnt_d [NUM];

    // Counts ungranted waiting cycles, saturating; any grant to the channel
    // or leaving WAIT starts the count over.
    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            starve_o[k]   = (wait_cnt_q[k] == CNT_MAX);
            wait_cnt_d[k] = wait_cnt_q[k];
            if (state_q[k] != S_WAIT || gnt_i[k]) begin
                wait_cnt_d[k] = '0;
            end else if (wait_cnt_q[k] != CNT_MAX) begin
                wait_cnt_d[k] = wait_cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM; k++) begin
                wait_cnt_q[k] <= '0;
            end
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign starve_o = '0;
`endif

endmodule
